// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment scanner with a shadow/active bank
// pair swapped at frame boundaries. SEG7_SCAN_LEADING_ZERO_BLANK_EN enables leading-zero suppression.
module seg7_scan_driver #(
   parameter int N_DIGITS     = 4,
   parameter int DIGIT_CYCLES = 27000,
   parameter int BLANK_CYCLES = 270
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [7*N_DIGITS-1:0]   seg_in,
   input  logic [N_DIGITS-1:0]     dp_in,
   input  logic                    load,
   output logic [6:0]              seg_out,
   output logic                    dp_out,
   output logic [N_DIGITS-1:0]     an,
   output logic                    pending,
   output logic                    frame_start
);

   localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
   localparam int DW = $clog2(N_DIGITS);

   logic [DW-1:0]           digit_q, digit_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [7*N_DIGITS-1:0]   shadowSeg_q, shadowSeg_d;
   logic [N_DIGITS-1:0]     shadowDp_q, shadowDp_d;
   logic [7*N_DIGITS-1:0]   activeSeg_q, activeSeg_d;
   logic [N_DIGITS-1:0]     activeDp_q, activeDp_d;
   logic                    pending_q, pending_d;
   logic [N_DIGITS-1:0]     an_q, an_d;
   logic [6:0]              seg_q, seg_d;
   logic                    dp_q, dp_d;
   logic                    frameStart_q, frameStart_d;

   logic                    lastCnt, lastDigit, boundary, onPhase, show;
   logic [6:0]              curSeg;
   logic                    curDp;
   logic                    digitHidden;

   assign lastCnt   = (cnt_q == CW'(DIGIT_CYCLES - 1));
   assign lastDigit = (digit_q == DW'(N_DIGITS - 1));
   assign boundary  = lastCnt && lastDigit;
   assign onPhase   = (cnt_q >= CW'(BLANK_CYCLES));

`ifdef SEG7_SCAN_LEADING_ZERO_BLANK_EN
   // Hide leading "0" glyphs (without decimal point) from the top digit down; digit 0 always shows.
   logic [N_DIGITS-1:0] suppress;
   logic                stillLeading;

   always_comb begin
      suppress     = '0;
      stillLeading = 1'b1;
      for (int i = N_DIGITS - 1; i >= 1; i--) begin
         if (stillLeading && (activeSeg_q[7*i +: 7] == 7'h40) && activeDp_q[i]) begin
            suppress[i] = 1'b1;
         end else begin
            stillLeading = 1'b0;
         end
      end
   end

   always_comb begin
      digitHidden = 1'b0;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (digit_q == DW'(i)) begin
            digitHidden = suppress[i];
         end
      end
   end
`else
   assign digitHidden = 1'b0;
`endif

   assign show = onPhase && !digitHidden;

   always_comb begin
      curSeg = 7'h7F;
      curDp  = 1'b1;
      an_d   = '1;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (digit_q == DW'(i)) begin
            curSeg  = activeSeg_q[7*i +: 7];
            curDp   = activeDp_q[i];
            an_d[i] = !show;
         end
      end
      seg_d        = show ? curSeg : 7'h7F;
      dp_d         = show ? curDp : 1'b1;
      frameStart_d = (digit_q == '0) && (cnt_q == '0);
   end

   always_comb begin
      cnt_d   = lastCnt ? '0 : cnt_q + 1'b1;
      digit_d = digit_q;
      if (lastCnt) begin
         digit_d = lastDigit ? '0 : digit_q + 1'b1;
      end
   end

   // A load coinciding with the boundary edge bypasses the shadow and lands in both banks at once.
   always_comb begin
      shadowSeg_d = shadowSeg_q;
      shadowDp_d  = shadowDp_q;
      activeSeg_d = activeSeg_q;
      activeDp_d  = activeDp_q;
      pending_d   = pending_q;
      if (load) begin
         shadowSeg_d = seg_in;
         shadowDp_d  = dp_in;
         pending_d   = 1'b1;
      end
      if (boundary) begin
         if (load) begin
            activeSeg_d = seg_in;
            activeDp_d  = dp_in;
            pending_d   = 1'b0;
         end else if (pending_q) begin
            activeSeg_d = shadowSeg_q;
            activeDp_d  = shadowDp_q;
            pending_d   = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digit_q      <= '0;
         cnt_q        <= '0;
         shadowSeg_q  <= '1;
         shadowDp_q   <= '1;
         activeSeg_q  <= '1;
         activeDp_q   <= '1;
         pending_q    <= 1'b0;
         an_q         <= '1;
         seg_q        <= 7'h7F;
         dp_q         <= 1'b1;
         frameStart_q <= 1'b0;
      end else begin
         digit_q      <= digit_d;
         cnt_q        <= cnt_d;
         shadowSeg_q  <= shadowSeg_d;
         shadowDp_q   <= shadowDp_d;
         activeSeg_q  <= activeSeg_d;
         activeDp_q   <= activeDp_d;
         pending_q    <= pending_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         frameStart_q <= frameStart_d;
      end
   end

   assign an          = an_q;
   assign seg_out     = seg_q;
   assign dp_out      = dp_q;
   assign pending     = pending_q;
   assign frame_start = frameStart_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with N_DIGITS=4, DIGIT_CYCLES=8, BLANK_CYCLES=2.
// Edge numbers count rising edges since the most recent reset release.
module tb_seg7_scan_driver;

   localparam int ND = 4;
   localparam int DC = 8;
   localparam int BC = 2;

`ifdef SEG7_SCAN_LEADING_ZERO_BLANK_EN
   localparam bit SupEn = 1'b1;
`else
   localparam bit SupEn = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic [27:0]   segIn;
   logic [3:0]    dpIn;
   logic          load;
   logic [6:0]    segOut;
   logic          dpOut;
   logic [3:0]    an;
   logic          pending;
   logic          frameStart;

   int total = 0;
   int bad   = 0;
   int k     = 0;

   seg7_scan_driver #(.N_DIGITS(ND), .DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
      .clk(clk), .rst_n(rst_n), .seg_in(segIn), .dp_in(dpIn), .load(load),
      .seg_out(segOut), .dp_out(dpOut), .an(an), .pending(pending), .frame_start(frameStart)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          edgeNo;
      bit          doLoad;
      logic [27:0] segV;
      logic [3:0]  dpV;
      bit          doCheck;
      logic [3:0]  expAn;
      logic [6:0]  expSeg;
      logic        expDp;
      logic        expPend;
      logic        expFs;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t ld(int e, logic [27:0] s, logic [3:0] d);
      vec_t v;
      v = '{edgeNo: e, doLoad: 1'b1, segV: s, dpV: d, doCheck: 1'b0,
            expAn: 4'hF, expSeg: 7'h7F, expDp: 1'b1, expPend: 1'b0, expFs: 1'b0};
      return v;
   endfunction

   function automatic vec_t chk(int e, logic [3:0] a, logic [6:0] s, logic d, logic p, logic f);
      vec_t v;
      v = '{edgeNo: e, doLoad: 1'b0, segV: '0, dpV: '0, doCheck: 1'b1,
            expAn: a, expSeg: s, expDp: d, expPend: p, expFs: f};
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s at edge %0d: got %0h want %0h", name, k, act, exp);
      end
   endtask

   task automatic checkAll(input string name, input logic [3:0] a, input logic [6:0] s,
                           input logic d, input logic p, input logic f);
      checkOutput({name, ".an"}, 32'(an), 32'(a));
      checkOutput({name, ".seg"}, 32'(segOut), 32'(s));
      checkOutput({name, ".dp"}, 32'(dpOut), 32'(d));
      checkOutput({name, ".pending"}, 32'(pending), 32'(p));
      checkOutput({name, ".frame_start"}, 32'(frameStart), 32'(f));
   endtask

   // Advance one rising edge and sample at the following falling edge.
   task automatic tick();
      @(posedge clk);
      k++;
      @(negedge clk);
      checkOutput("an_onehot", 32'($countones(~an) <= 1), 32'd1);
   endtask

   task automatic advanceTo(input int e);
      while (k < e) tick();
   endtask

   task automatic applyStimulus(input logic [27:0] s, input logic [3:0] d);
      segIn = s;
      dpIn  = d;
      load  = 1'b1;
      tick();
      load  = 1'b0;
   endtask

   initial begin
      logic [3:0] expAn;
      int p;

      rst_n = 1'b1;
      load  = 1'b0;
      segIn = '1;
      dpIn  = '1;
      #2 rst_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      checkAll("reset", 4'hF, 7'h7F, 1'b1, 1'b0, 1'b0);
      rst_n = 1'b1;
      k = 0;

      // Two frames of free-running scan with blank banks.
      for (int e = 1; e <= 64; e++) begin
         tick();
         p = (k - 1) % 32;
         expAn = 4'hF;
         if ((p % 8) >= BC) expAn[p / 8] = 1'b0;
         checkAll("freerun", expAn, 7'h7F, 1'b1, 1'b0, ((k % 32) == 1));
      end

      vecs.push_back(chk(69,  4'b1110, 7'h7F, 1'b1, 1'b0, 1'b0));
      vecs.push_back(ld (70,  {7'h30, 7'h24, 7'h79, 7'h40}, 4'hF));
      vecs.push_back(chk(70,  4'b1110, 7'h7F, 1'b1, 1'b1, 1'b0));
      vecs.push_back(chk(75,  4'b1101, 7'h7F, 1'b1, 1'b1, 1'b0));
      vecs.push_back(chk(95,  4'b0111, 7'h7F, 1'b1, 1'b1, 1'b0));
      vecs.push_back(chk(96,  4'b0111, 7'h7F, 1'b1, 1'b0, 1'b0));
      vecs.push_back(chk(97,  4'b1111, 7'h7F, 1'b1, 1'b0, 1'b1));
      vecs.push_back(chk(99,  4'b1110, 7'h40, 1'b1, 1'b0, 1'b0));
      vecs.push_back(chk(104, 4'b1110, 7'h40, 1'b1, 1'b0, 1'b0));
      vecs.push_back(chk(105, 4'b1111, 7'h7F, 1'b1, 1'b0, 1'b0));
      vecs.push_back(chk(106, 4'b1111, 7'h7F, 1'b1, 1'b0, 1'b0));
      vecs.push_back(chk(107, 4'b1101, 7'h79, 1'b1, 1'b0, 1'b0));
      vecs.push_back(chk(115, 4'b1011, 7'h24, 1'b1, 1'b0, 1'b0));
      vecs.push_back(chk(123, 4'b0111, 7'h30, 1'b1, 1'b0, 1'b0));
      vecs.push_back(ld (135, {4{7'h79}}, 4'hF));
      vecs.push_back(chk(135, 4'b1110, 7'h40, 1'b1, 1'b1, 1'b0));
      vecs.push_back(ld (140, {4{7'h24}}, 4'b1110));
      vecs.push_back(chk(140, 4'b1101, 7'h79, 1'b1, 1'b1, 1'b0));
      vecs.push_back(chk(160, 4'b0111, 7'h30, 1'b1, 1'b0, 1'b0));
      vecs.push_back(chk(163, 4'b1110, 7'h24, 1'b0, 1'b0, 1'b0));
      vecs.push_back(chk(171, 4'b1101, 7'h24, 1'b1, 1'b0, 1'b0));
      vecs.push_back(chk(187, 4'b0111, 7'h24, 1'b1, 1'b0, 1'b0));
      vecs.push_back(ld (192, {7'h12, 7'h19, 7'h30, 7'h00}, 4'hF));
      vecs.push_back(chk(192, 4'b0111, 7'h24, 1'b1, 1'b0, 1'b0));
      vecs.push_back(chk(193, 4'b1111, 7'h7F, 1'b1, 1'b0, 1'b1));
      vecs.push_back(chk(195, 4'b1110, 7'h00, 1'b1, 1'b0, 1'b0));
      vecs.push_back(chk(203, 4'b1101, 7'h30, 1'b1, 1'b0, 1'b0));

      foreach (vecs[i]) begin
         advanceTo(vecs[i].edgeNo - 1);
         if (vecs[i].doLoad) begin
            applyStimulus(vecs[i].segV, vecs[i].dpV);
         end else if (k < vecs[i].edgeNo) begin
            tick();
         end
         if (vecs[i].doCheck) begin
            checkAll($sformatf("vec%0d", i), vecs[i].expAn, vecs[i].expSeg,
                     vecs[i].expDp, vecs[i].expPend, vecs[i].expFs);
         end
      end

      // Pending data queued, then reset pulsed during digit 2 ON phase.
      advanceTo(239);
      applyStimulus({4{7'h00}}, 4'h0);
      checkOutput("pre_reset.pending", 32'(pending), 32'd1);
      advanceTo(245);
      checkAll("digit2_on", 4'b1011, 7'h19, 1'b1, 1'b1, 1'b0);
      #1 rst_n = 1'b0;
      #1 checkAll("async_reset", 4'hF, 7'h7F, 1'b1, 1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      k = 0;
      tick();
      checkAll("restart_e1", 4'hF, 7'h7F, 1'b1, 1'b0, 1'b1);
      advanceTo(3);
      checkAll("restart_e3", 4'b1110, 7'h7F, 1'b1, 1'b0, 1'b0);
      advanceTo(33);
      checkAll("restart_e33", 4'hF, 7'h7F, 1'b1, 1'b0, 1'b1);
      advanceTo(35);
      checkAll("restart_e35", 4'b1110, 7'h7F, 1'b1, 1'b0, 1'b0);

      // Digits 3..0 = 0,0,7,0: the top two are leading zeros.
      advanceTo(39);
      applyStimulus({7'h40, 7'h40, 7'h78, 7'h40}, 4'hF);
      checkOutput("lz_load.pending", 32'(pending), 32'd1);
      advanceTo(67);
      checkAll("lz_d0", 4'b1110, 7'h40, 1'b1, 1'b0, 1'b0);
      advanceTo(75);
      checkAll("lz_d1", 4'b1101, 7'h78, 1'b1, 1'b0, 1'b0);
      advanceTo(83);
      checkAll("lz_d2", SupEn ? 4'b1111 : 4'b1011, SupEn ? 7'h7F : 7'h40, 1'b1, 1'b0, 1'b0);
      advanceTo(91);
      checkAll("lz_d3", SupEn ? 4'b1111 : 4'b0111, SupEn ? 7'h7F : 7'h40, 1'b1, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
